// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch FSM encoding, bus widths and the bubble instruction word.
package pipeline_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'hD503201F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_t;

    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Counts memory wait-state cycles for an outstanding fetch.
// term goes high once the count equals TIMEOUT.
module fetch_wait_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic term
);

    localparam logic [7:0] TC = TIMEOUT[7:0];

    logic [7:0] count;

    // Saturating up-counter; clear wins over enable.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign term = (count == TC);

endmodule

// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: PC -> imem read -> IF/ID register.
// Absorbs wait states and decode stalls, handles flush and timeout.
module pipeline_fetch_unit #(
    parameter int TIMEOUT = 16,
    parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        misalign,
    output logic        fetch_fault
);

    import pipeline_pkg::*;

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [63:0] req_pc;
    logic [31:0] hold_instr;
    logic [63:0] hold_pc;

    logic aligned;
    logic in_fetch;
    logic in_wait;
    logic in_drain;
    logic capture;
    logic wait_fail;
    logic cnt_run;
    logic wait_tc;
    logic [63:0] cap_pc;

    assign aligned  = is_aligned(PC);
    assign in_fetch = (state == ST_FETCH);
    assign in_wait  = (state == ST_WAIT);
    assign in_drain = (state == ST_DRAIN);

    // Data accepted from memory this cycle (drain data is discarded).
    assign capture = imem_ready
                   && ((in_fetch && aligned) || in_wait);

    // Outstanding request ran out of time without data.
    assign wait_fail = (in_wait || in_drain)
                     && !imem_ready && wait_tc;

    assign cap_pc = in_fetch ? PC : req_pc;

    assign imem_req = (in_fetch && aligned)
                    || in_wait || in_drain;

    assign imem_addr = in_fetch ? PC : req_pc;

    assign fetch_busy = !(in_fetch && aligned && imem_ready);

    // Counter runs only while a request is parked in WAIT/DRAIN.
    assign cnt_run = (state_nx == ST_WAIT)
                   || (state_nx == ST_DRAIN);

    fetch_wait_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (!cnt_run),
        .enable(cnt_run),
        .term  (wait_tc)
    );

    // Next-state decode for the fetch FSM.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                if (!aligned) begin
                    state_nx = ST_FETCH;
                end else if (flush) begin
                    state_nx = ST_FETCH;
                end else if (imem_ready) begin
                    state_nx = stall ? ST_HOLD : ST_FETCH;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    if (flush)
                        state_nx = ST_FETCH;
                    else
                        state_nx = stall ? ST_HOLD : ST_FETCH;
                end else if (wait_tc) begin
                    state_nx = ST_FAULT;
                end else if (flush) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ready)
                    state_nx = ST_FETCH;
                else if (wait_tc)
                    state_nx = ST_FAULT;
            end
            ST_HOLD: begin
                if (flush || !stall)
                    state_nx = ST_FETCH;
            end
            ST_FAULT: begin
                state_nx = ST_FAULT;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register and latched request address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nx;
            if (in_fetch && aligned)
                req_pc <= PC;
        end
    end

    // IF/ID register, hold buffer and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction <= NOP_WORD;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            fetch_fault <= 1'b0;
            hold_instr  <= NOP_WORD;
            hold_pc     <= '0;
        end else begin
            misalign <= in_fetch && !aligned;
            if (wait_fail)
                fetch_fault <= 1'b1;

            if (flush) begin
                instruction <= NOP_WORD;
                instr_pc    <= '0;
                instr_valid <= 1'b0;
                hold_instr  <= NOP_WORD;
                hold_pc     <= '0;
            end else if (wait_fail) begin
                instruction <= NOP_WORD;
                instr_valid <= 1'b0;
            end else if (in_fetch && !aligned) begin
                if (!stall) begin
                    instruction <= NOP_WORD;
                    instr_valid <= 1'b0;
                end
            end else if (capture) begin
                if (stall) begin
                    hold_instr <= imem_rdata;
                    hold_pc    <= cap_pc;
                end else begin
                    instruction <= imem_rdata;
                    instr_pc    <= cap_pc;
                    instr_valid <= 1'b1;
                end
            end else if (state == ST_HOLD && !stall) begin
                instruction <= hold_instr;
                instr_pc    <= hold_pc;
                instr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Directed, table-driven bench for pipeline_fetch_unit.
// Each row is one clock: inputs, in-cycle outputs, post-edge regs.
module tb_pipeline_fetch_unit;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic [63:0] PC;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        fetch_busy;
    logic        misalign;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        fls;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_busy;
        logic [31:0] e_instr;
        logic [63:0] e_ipc;
        logic        chk_ipc;
        logic        e_valid;
        logic        e_mis;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];

    pipeline_fetch_unit #(
        .TIMEOUT (4),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .fetch_busy (fetch_busy),
        .misalign   (misalign),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [63:0] pc, input logic rdy,
        input logic [31:0] rdata, input logic stl,
        input logic fls, input logic e_req,
        input logic [63:0] e_addr, input logic e_busy,
        input logic [31:0] e_instr, input logic [63:0] e_ipc,
        input logic chk_ipc, input logic e_valid,
        input logic e_mis, input logic e_fault);
        vec_t v;
        v.pc = pc;       v.rdy = rdy;       v.rdata = rdata;
        v.stl = stl;     v.fls = fls;       v.e_req = e_req;
        v.e_addr = e_addr;   v.e_busy = e_busy;
        v.e_instr = e_instr; v.e_ipc = e_ipc;
        v.chk_ipc = chk_ipc; v.e_valid = e_valid;
        v.e_mis = e_mis;     v.e_fault = e_fault;
        return v;
    endfunction

    initial begin
        vec_t v;
        // pc rdy rdata stl fls | req addr busy | instr ipc chk val mis flt
        // IDLE then three zero-wait fetches
        tbl.push_back(mk(64'h00,1,32'h0,0,0, 0,64'h0,1, NOP,64'h0,1,0,0,0));
        tbl.push_back(mk(64'h00,1,32'h11110001,0,0, 1,64'h00,0,
                         32'h11110001,64'h00,1,1,0,0));
        tbl.push_back(mk(64'h04,1,32'h11110002,0,0, 1,64'h04,0,
                         32'h11110002,64'h04,1,1,0,0));
        tbl.push_back(mk(64'h08,1,32'h11110003,0,0, 1,64'h08,0,
                         32'h11110003,64'h08,1,1,0,0));
        // 3 wait states at 0x40; PC change during WAIT is ignored
        tbl.push_back(mk(64'h40,0,32'h0,0,0, 1,64'h40,1,
                         32'h11110003,64'h08,1,1,0,0));
        tbl.push_back(mk(64'h44,0,32'h0,0,0, 1,64'h40,1,
                         32'h11110003,64'h08,1,1,0,0));
        tbl.push_back(mk(64'h44,0,32'h0,0,0, 1,64'h40,1,
                         32'h11110003,64'h08,1,1,0,0));
        tbl.push_back(mk(64'h44,1,32'h8B020020,0,0, 1,64'h40,1,
                         32'h8B020020,64'h40,1,1,0,0));
        // stall in capture cycle -> HOLD, no request while held
        tbl.push_back(mk(64'h48,1,32'hB0000001,1,0, 1,64'h48,0,
                         32'h8B020020,64'h40,1,1,0,0));
        tbl.push_back(mk(64'h4C,1,32'hBADBAD00,1,0, 0,64'h0,1,
                         32'h8B020020,64'h40,1,1,0,0));
        tbl.push_back(mk(64'h4C,1,32'hBADBAD00,0,0, 0,64'h0,1,
                         32'hB0000001,64'h48,1,1,0,0));
        // flush in WAIT -> DRAIN, late data discarded
        tbl.push_back(mk(64'h50,0,32'h0,0,0, 1,64'h50,1,
                         32'hB0000001,64'h48,1,1,0,0));
        tbl.push_back(mk(64'h50,0,32'h0,0,1, 1,64'h50,1,
                         NOP,64'h0,1,0,0,0));
        tbl.push_back(mk(64'h60,0,32'h0,0,0, 1,64'h50,1,
                         NOP,64'h0,1,0,0,0));
        tbl.push_back(mk(64'h60,1,32'hDEADBEEF,0,0, 1,64'h50,1,
                         NOP,64'h0,1,0,0,0));
        tbl.push_back(mk(64'h60,1,32'hC0000001,0,0, 1,64'h60,0,
                         32'hC0000001,64'h60,1,1,0,0));
        // misaligned PC: no request, one-cycle misalign pulse
        tbl.push_back(mk(64'h42,1,32'hBADBAD01,0,0, 0,64'h0,1,
                         NOP,64'h0,0,0,1,0));
        tbl.push_back(mk(64'h64,1,32'hC0000002,0,0, 1,64'h64,0,
                         32'hC0000002,64'h64,1,1,0,0));
        // flush beats stall and capture in FETCH
        tbl.push_back(mk(64'h68,1,32'hBADBAD02,1,1, 1,64'h68,0,
                         NOP,64'h0,1,0,0,0));
        tbl.push_back(mk(64'h6C,1,32'hC0000003,0,0, 1,64'h6C,0,
                         32'hC0000003,64'h6C,1,1,0,0));
        // ready exactly at count==TIMEOUT: capture, no fault
        tbl.push_back(mk(64'h80,0,32'h0,0,0, 1,64'h80,1,
                         32'hC0000003,64'h6C,1,1,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(64'h80,0,32'h0,0,0, 1,64'h80,1,
                             32'hC0000003,64'h6C,1,1,0,0));
        tbl.push_back(mk(64'h80,1,32'hD0000001,0,0, 1,64'h80,1,
                         32'hD0000001,64'h80,1,1,0,0));
        // no ready: 4 WAIT cycles then FAULT
        tbl.push_back(mk(64'h90,0,32'h0,0,0, 1,64'h90,1,
                         32'hD0000001,64'h80,1,1,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(64'h90,0,32'h0,0,0, 1,64'h90,1,
                             32'hD0000001,64'h80,1,1,0,0));
        tbl.push_back(mk(64'h90,0,32'h0,0,0, 1,64'h90,1,
                         NOP,64'h0,0,0,0,1));
        // FAULT absorbs even with ready high
        tbl.push_back(mk(64'h94,1,32'hBADBAD03,0,0, 0,64'h0,1,
                         NOP,64'h0,0,0,0,1));
        tbl.push_back(mk(64'h98,1,32'hBADBAD04,0,0, 0,64'h0,1,
                         NOP,64'h0,0,0,0,1));

        reset = 1'b1;
        PC = '0;
        stall = 1'b0;
        flush = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst instr", instruction, NOP);
        chk("rst ipc", instr_pc, 64'h0);
        chk("rst valid", instr_valid, 1'b0);
        chk("rst mis", misalign, 1'b0);
        chk("rst fault", fetch_fault, 1'b0);
        chk("rst req", imem_req, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            PC = v.pc;
            imem_ready = v.rdy;
            imem_rdata = v.rdata;
            stall = v.stl;
            flush = v.fls;
            @(negedge clk);
            chk($sformatf("r%0d req", i), imem_req, v.e_req);
            if (v.e_req)
                chk($sformatf("r%0d addr", i), imem_addr, v.e_addr);
            chk($sformatf("r%0d busy", i), fetch_busy, v.e_busy);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d instr", i), instruction, v.e_instr);
            if (v.chk_ipc)
                chk($sformatf("r%0d ipc", i), instr_pc, v.e_ipc);
            chk($sformatf("r%0d valid", i), instr_valid, v.e_valid);
            chk($sformatf("r%0d mis", i), misalign, v.e_mis);
            chk($sformatf("r%0d fault", i), fetch_fault, v.e_fault);
        end

        // reset clears the sticky fault and restarts from IDLE
        reset = 1'b1;
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2 fault", fetch_fault, 1'b0);
        chk("rst2 instr", instruction, NOP);
        chk("rst2 valid", instr_valid, 1'b0);
        reset = 1'b0;
        PC = 64'h100;
        imem_ready = 1'b1;
        imem_rdata = 32'hE0000001;
        @(negedge clk);
        chk("idle req", imem_req, 1'b0);
        chk("idle busy", fetch_busy, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post req", imem_req, 1'b1);
        chk("post busy", fetch_busy, 1'b0);
        @(posedge clk);
        #1;
        chk("post instr", instruction, 32'hE0000001);
        chk("post ipc", instr_pc, 64'h100);
        chk("post valid", instr_valid, 1'b1);
        chk("post fault", fetch_fault, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
